// File: rtl/adder_pipe_nbit_pkg.sv
// Shared definitions for the pipelined adder: operation encoding and the
// signed-overflow rule used by the final stage.
package adder_pkg;

  // Operation select encoding on the sub input.
  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  // Two's-complement overflow: both addends share a sign and the result
  // sign differs from it. b_eff_msb is the MSB after the subtract inversion.
  function automatic logic overflow_rule(input logic a_msb,
                                         input logic b_eff_msb,
                                         input logic sum_msb);
    return (a_msb == b_eff_msb) && (sum_msb != a_msb);
  endfunction

endpackage

// File: rtl/adder_pipe_nbit_if.sv
// Streaming bus of the pipelined adder: operand beat in, result beat out,
// each side with its own valid/ready pair.
interface adder_pipe_nbit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             zero;

  // Producer of operands / consumer of results.
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, overflow, zero
  );

  // The adder itself.
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, overflow, zero
  );
endinterface

// File: rtl/adder_pipe_nbit_slice.sv
// One SLICE-bit adder cell; purely combinational, one instance per stage.
module adder_slice #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] x,
  input  logic [SLICE-1:0] y,
  input  logic             ci,
  output logic [SLICE-1:0] s,
  output logic             co
);

  // Widen by one bit so the carry out of the slice falls out of the add.
  assign {co, s} = {1'b0, x} + {1'b0, y} + {{SLICE{1'b0}}, ci};

endmodule

// File: rtl/adder_pipe_nbit.sv
// Pipelined WIDTH-bit add/subtract. Each stage adds one SLICE-bit slice and
// registers its carry for the next stage; the operand words travel with the
// beat so later stages find their slices aligned. The last stage owns the
// visible result registers, which only update when a valid beat lands there.
module adder_pipe_nbit
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input logic              clk,
  input logic              rst,
  adder_pipe_nbit_if.slave bus
);

  localparam int STAGES = WIDTH / SLICE;

  // Reject illegal geometry at elaboration time.
  if ((WIDTH % SLICE) != 0 || WIDTH < 2 || SLICE < 1) begin : g_bad_geometry
    $error("adder_pipe_nbit: WIDTH must be a multiple of SLICE and >= 2");
  end

  // Inputs to stage k. Index 0 is the incoming beat; index k>0 is the
  // register bank written by stage k-1.
  logic             st_valid [STAGES];
  logic             st_c     [STAGES];
  logic [WIDTH-1:0] st_a     [STAGES];
  logic [WIDTH-1:0] st_b     [STAGES];
  logic [WIDTH-1:0] st_sum   [STAGES];

  // Visible result registers, written by the final stage.
  logic             out_valid_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             overflow_reg;
  logic             zero_reg;

  // The whole pipeline moves together: it advances unless a result is
  // waiting that downstream refuses. Bubbles therefore advance too.
  logic advance;
  assign advance = bus.out_ready || !out_valid_reg;

  // Subtract is a + ~b + 1, with the borrow-in folded into the carry-in.
  assign st_valid[0] = bus.in_valid;
  assign st_a[0]     = bus.a;
  assign st_b[0]     = bus.b ^ {WIDTH{bus.sub != ADD}};
  assign st_c[0]     = bus.cin ^ (bus.sub == SUB);
  assign st_sum[0]   = '0;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    logic [SLICE-1:0] slice_s;
    logic             slice_co;
    logic [WIDTH-1:0] psum_next;

    adder_slice #(
      .SLICE (SLICE)
    ) u_slice (
      .x  (st_a[gi][gi*SLICE +: SLICE]),
      .y  (st_b[gi][gi*SLICE +: SLICE]),
      .ci (st_c[gi]),
      .s  (slice_s),
      .co (slice_co)
    );

    // Merge this stage's slice into the partial sum carried by the beat.
    always_comb begin
      psum_next = st_sum[gi];
      psum_next[gi*SLICE +: SLICE] = slice_s;
    end

    if (gi < STAGES - 1) begin : g_mid
      logic             valid_reg;
      logic             c_reg;
      logic [WIDTH-1:0] a_reg;
      logic [WIDTH-1:0] b_reg;
      logic [WIDTH-1:0] psum_reg;

      // Intermediate stage register: beat, carry and partial sum move on.
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg <= 1'b0;
          c_reg     <= 1'b0;
          a_reg     <= '0;
          b_reg     <= '0;
          psum_reg  <= '0;
        end else if (advance) begin
          valid_reg <= st_valid[gi];
          c_reg     <= slice_co;
          a_reg     <= st_a[gi];
          b_reg     <= st_b[gi];
          psum_reg  <= psum_next;
        end
      end

      assign st_valid[gi+1] = valid_reg;
      assign st_c[gi+1]     = c_reg;
      assign st_a[gi+1]     = a_reg;
      assign st_b[gi+1]     = b_reg;
      assign st_sum[gi+1]   = psum_reg;
    end else begin : g_last
      // Final stage: flags are derived from the completed sum and kept
      // until the next valid beat, so bubbles never disturb them.
      always_ff @(posedge clk) begin
        if (rst) begin
          out_valid_reg <= 1'b0;
          sum_reg       <= '0;
          cout_reg      <= 1'b0;
          overflow_reg  <= 1'b0;
          zero_reg      <= 1'b0;
        end else if (advance) begin
          out_valid_reg <= st_valid[gi];
          if (st_valid[gi]) begin
            sum_reg      <= psum_next;
            cout_reg     <= slice_co;
            overflow_reg <= overflow_rule(st_a[gi][WIDTH-1], st_b[gi][WIDTH-1],
                                          psum_next[WIDTH-1]);
            zero_reg     <= (psum_next == '0);
          end
        end
      end
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = out_valid_reg;
  assign bus.sum       = sum_reg;
  assign bus.cout      = cout_reg;
  assign bus.overflow  = overflow_reg;
  assign bus.zero      = zero_reg;

endmodule

// File: doc/adder_pipe_nbit.md
Name: adder_pipe_nbit

Overview:
- Parametrised, pipelined successor to the team's 16-bit ripple adder.
- Computes a + b + cin, or a − b − cin in subtract mode, over WIDTH bits, SLICE bits per pipeline stage.
- Carry is registered between stages, and operands are skewed so that each stage adds one slice per cycle.
- Sits on datapath arithmetic paths with valid/ready streaming on both sides. Produces sum, cout, signed overflow and zero flags.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of SLICE and ≥ 2.
- SLICE, 8, bits added per pipeline stage; STAGES = WIDTH/SLICE is the latency.

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block accepts a beat this cycle
- a  in  WIDTH  first operand
- b  in  WIDTH  second operand
- cin  in  1  carry-in (add) / borrow-in (sub)
- sub  in  1  0 = add, 1 = subtract
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  result
- cout  out  1  carry out of MSB (for sub: 1 = no borrow)
- overflow  out  1  signed two's-complement overflow
- zero  out  1  sum == 0

Behaviour:
- Single clock domain. rst is synchronous and active-high, and overrides everything.
- Reset state:
  - all stage valid bits = 0, so out_valid = 0
  - sum = 0, cout = 0, overflow = 0, zero = 0
  - in_ready = 1 once rst is low
- Effective operation is computed modulo 2^WIDTH with carry cout:
  - b_eff = b XOR {WIDTH{sub}}
  - c0 = cin XOR sub
  - result = a + b_eff + c0
  - Hence sub=1, cin=0 gives a − b; sub=1, cin=1 gives a − b − 1.
- Overflow = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]), evaluated on the captured operands.
- Accept rule:
  - A beat is accepted when in_valid && in_ready.
  - in_ready = out_ready || !out_valid, i.e. a global pipeline advance enable.
- Pipeline:
  - STAGES register stages. Stage k adds slice k (bits k·SLICE .. k·SLICE+SLICE−1) using the carry registered by stage k−1.
  - Stage 0 uses c0.
  - Upper operand slices and the MSB sign bits travel with the beat.
- Latency is exactly STAGES cycles from acceptance to out_valid when unstalled. Throughput is 1 beat/cycle.
- Stall (out_valid && !out_ready): every stage holds; sum, cout, overflow and zero hold stable; in_ready = 0.
- Bubbles: an invalid stage still advances when enabled. Data in invalid stages is don't-care, but outputs only change when a valid beat arrives at the last stage or on reset.
- Output hold: outputs hold the last valid result after out_valid drops.
- Simultaneous output consume and input accept in one cycle is allowed; there is no dead cycle.
- Reset mid-operation: all in-flight beats are discarded and no partial result is emitted.
- Boundaries:
  - SLICE == WIDTH degenerates to a single registered stage with latency 1.
  - Wrap-around at 2^WIDTH sets cout only.
  - zero is computed on the full registered sum.

Decomposition:
- Package adder_pkg: the sub-mode encoding constants ADD = 1'b0 and SUB = 1'b1, and a function for the overflow rule.
- Sub-module adder_slice:
  - combinational, SLICE-bit ripple adder
  - inputs x, y, ci; outputs s, co
  - instantiated STAGES times via generate

Test Plan (WIDTH=32, SLICE=8, latency 4):
- Reset then idle: rst high 2 cycles → out_valid=0, sum=0, cout=0, overflow=0, zero=0, in_ready=1.
- Add with carry chain: a=0x0000_FFFF, b=0x0000_0001, cin=0, sub=0 → 4 cycles later sum=0x0001_0000, cout=0, overflow=0, zero=0.
- Wrap and zero: a=0xFFFF_FFFF, b=0x0000_0000, cin=1 → sum=0, cout=1, zero=1, overflow=0.
- Signed overflow and subtract:
  - a=0x7FFF_FFFF, b=1, add → sum=0x8000_0000, overflow=1.
  - a=5, b=7, sub=1, cin=0 → sum=0xFFFF_FFFE, cout=0, overflow=0.
- Streaming with backpressure: 8 back-to-back beats (a=i, b=i, i=0..7) with out_ready low for cycles 6–8 → results 2i in order, none lost or duplicated, outputs stable while stalled, in_ready=0 during stall.
- Reset mid-flight: 3 beats accepted, rst asserted 1 cycle before the first would emerge → no out_valid afterwards until new input; next beat a=1, b=1 emerges after 4 cycles with sum=2.
